// File: rtl/id_stage_pipe_pkg.sv
// id_stage_pipe_pkg
// Shared definitions for the MIPS64 ID stage: datapath defaults, control-bus
// widths, the MEM-bus load flag position, opcode constants and the shared
// controller decode that turns an opcode into EX/MEM/WB control buses.
//
// Control bus layouts produced by decode_ctrl():
//   IE  [3:0] alu_op, [4] alu_src_imm, [5] reg_dst_rd, [6] branch, [7] zero_ext
//   MEM [0] mem_read, [1] mem_write, [2] dword
//   WB  [0] reg_write, [1] mem_to_reg
package id_stage_pipe_pkg;

  localparam int WIDTH_DEF         = 64;
  localparam int ADDR_DEF          = 5;
  localparam int IE_CTRL_SIZE_DEF  = 8;
  localparam int MEM_CTRL_SIZE_DEF = 3;
  localparam int WB_CTRL_SIZE_DEF  = 2;
  localparam int MEM_READ_BIT_DEF  = 0;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_DADDI  = 6'h18;
  localparam logic [5:0] OP_DADDIU = 6'h19;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_LD     = 6'h37;
  localparam logic [5:0] OP_SD     = 6'h3F;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_LUI   = 4'd5,
    ALU_FUNCT = 4'd6,
    ALU_SLT   = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic [IE_CTRL_SIZE_DEF-1:0]  ie;
    logic [MEM_CTRL_SIZE_DEF-1:0] mem;
    logic [WB_CTRL_SIZE_DEF-1:0]  wb;
  } ctrl_t;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t   c;
    alu_op_e alu;
    logic    src, dst, br, zx;
    logic    rd, wr, dw;
    logic    rw, m2r;
    alu = ALU_ADD;
    src = 1'b0; dst = 1'b0; br = 1'b0; zx = 1'b0;
    rd  = 1'b0; wr  = 1'b0; dw = 1'b0;
    rw  = 1'b0; m2r = 1'b0;
    case (op)
      OP_RTYPE: begin
        alu = ALU_FUNCT; dst = 1'b1; rw = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_DADDI, OP_DADDIU: begin
        src = 1'b1; rw = 1'b1;
      end
      OP_SLTI: begin
        alu = ALU_SLT; src = 1'b1; rw = 1'b1;
      end
      OP_ANDI: begin
        alu = ALU_AND; src = 1'b1; zx = 1'b1; rw = 1'b1;
      end
      OP_ORI: begin
        alu = ALU_OR; src = 1'b1; zx = 1'b1; rw = 1'b1;
      end
      OP_XORI: begin
        alu = ALU_XOR; src = 1'b1; zx = 1'b1; rw = 1'b1;
      end
      OP_LUI: begin
        alu = ALU_LUI; src = 1'b1; rw = 1'b1;
      end
      OP_LW, OP_LD: begin
        src = 1'b1; rd = 1'b1; rw = 1'b1; m2r = 1'b1;
        dw  = (op == OP_LD);
      end
      OP_SW, OP_SD: begin
        src = 1'b1; wr = 1'b1;
        dw  = (op == OP_SD);
      end
      OP_BEQ, OP_BNE: begin
        alu = ALU_SUB; br = 1'b1;
      end
      default: begin
      end
    endcase
    c.ie  = {zx, br, dst, src, alu};
    c.mem = {dw, wr, rd};
    c.wb  = {m2r, rw};
    return c;
  endfunction

endpackage

// File: rtl/id_stage_pipe_hazard.sv
// id_hazard_unit
// Combinational load-use hazard detector. A hazard exists when the bundle
// currently held in ID/EX is a valid load writing a non-zero register that
// the instruction now in ID reads as rs or rt.
//
// Ports:
//   rs_i, rt_i       source register fields of the instruction in ID
//   ex_rt_i          destination (rt) of the held ID/EX bundle
//   ex_mem_read_i    load flag of the held ID/EX bundle
//   ex_valid_i       held ID/EX bundle is valid
//   hazard_o         load-use hazard this cycle
module id_hazard_unit #(
  parameter int ADDR = 5
) (
  input  logic [ADDR-1:0] rs_i,
  input  logic [ADDR-1:0] rt_i,
  input  logic [ADDR-1:0] ex_rt_i,
  input  logic            ex_mem_read_i,
  input  logic            ex_valid_i,
  output logic            hazard_o
);

  logic dest_live;
  logic src_match;

  assign dest_live = ex_valid_i && ex_mem_read_i && (ex_rt_i != '0);
  assign src_match = (ex_rt_i == rs_i) || (ex_rt_i == rt_i);
  assign hazard_o  = dest_live && src_match;

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe
// MIPS64 instruction-decode stage. Holds the 2^ADDR-entry register file,
// decodes each instruction into operands, extended immediate and control
// buses, and registers the result at the ID/EX boundary. Load-use hazards
// are detected locally and turned into a one-cycle bubble.
//
// Optional feature macro: ID_WB_BYPASS_EN
//   defined   : a write-back to rs/rt in the same cycle is forwarded to the
//               operand read.
//   undefined : operands come from the array only (old value on same-cycle
//               write); downstream forwarding must cover this case.
//
// Ports:
//   p_clk, p_reset_l        clock, synchronous active-low reset
//   p_IF_Valid/Instruction  instruction from IF
//   p_ID_Stall              combinational: IF must hold its instruction
//   p_EX_Stall              EX cannot accept; ID/EX registers hold
//   p_Flush                 squash the instruction in ID
//   p_WB_WE/Addr/Data       register file write-back port
//   p_EX_Valid              ID/EX bundle valid
//   p_DataA, p_DataB        rs/rt operands
//   p_Immediate             extended immediate
//   p_RT_RegDest/RD_RegDest instr[20:16] / instr[15:11]
//   p_*_Ctrl_Bus            EX/MEM/WB control buses
// WIDTH must be at least 16.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int ADDR          = ADDR_DEF,
  parameter int IE_CTRL_SIZE  = IE_CTRL_SIZE_DEF,
  parameter int MEM_CTRL_SIZE = MEM_CTRL_SIZE_DEF,
  parameter int WB_CTRL_SIZE  = WB_CTRL_SIZE_DEF,
  parameter int MEM_READ_BIT  = MEM_READ_BIT_DEF
) (
  input  logic                     p_clk,
  input  logic                     p_reset_l,
  input  logic                     p_IF_Valid,
  input  logic [31:0]              p_IF_Instruction,
  output logic                     p_ID_Stall,
  input  logic                     p_EX_Stall,
  input  logic                     p_Flush,
  input  logic                     p_WB_WE,
  input  logic [ADDR-1:0]          p_WB_Addr,
  input  logic [WIDTH-1:0]         p_WB_Data,
  output logic                     p_EX_Valid,
  output logic [WIDTH-1:0]         p_DataA,
  output logic [WIDTH-1:0]         p_DataB,
  output logic [WIDTH-1:0]         p_Immediate,
  output logic [ADDR-1:0]          p_RT_RegDest,
  output logic [ADDR-1:0]          p_RD_RegDest,
  output logic [IE_CTRL_SIZE-1:0]  p_IE_Ctrl_Bus,
  output logic [MEM_CTRL_SIZE-1:0] p_MEM_Ctrl_Bus,
  output logic [WB_CTRL_SIZE-1:0]  p_WB_Ctrl_Bus
);

  localparam int DEPTH = 1 << ADDR;

  // ---------------- field decode ----------------
  logic [5:0]      opcode;
  logic [15:0]     imm16;
  logic [ADDR-1:0] rs, rt, rd;

  assign opcode = p_IF_Instruction[31:26];
  assign imm16  = p_IF_Instruction[15:0];
  assign rs     = ADDR'(p_IF_Instruction[25:21]);
  assign rt     = ADDR'(p_IF_Instruction[20:16]);
  assign rd     = ADDR'(p_IF_Instruction[15:11]);

  ctrl_t dec;
  assign dec = decode_ctrl(opcode);

  logic [IE_CTRL_SIZE-1:0]  ie_d;
  logic [MEM_CTRL_SIZE-1:0] mem_d;
  logic [WB_CTRL_SIZE-1:0]  wb_d;

  // An invalid slot must not carry live control into EX.
  assign ie_d  = p_IF_Valid ? IE_CTRL_SIZE'(dec.ie)   : '0;
  assign mem_d = p_IF_Valid ? MEM_CTRL_SIZE'(dec.mem) : '0;
  assign wb_d  = p_IF_Valid ? WB_CTRL_SIZE'(dec.wb)   : '0;

  // ---------------- immediate extension ----------------
  logic [WIDTH-1:0] imm_zext, imm_sext, imm_d;

  assign imm_zext = WIDTH'(imm16);
  assign imm_sext = WIDTH'($signed(imm16));
  assign imm_d    = is_zext_op(opcode) ? imm_zext : imm_sext;

  // ---------------- register file ----------------
  logic [WIDTH-1:0] rf_q [DEPTH];

  always_ff @(posedge p_clk) begin
    if (!p_reset_l) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else if (p_WB_WE && (p_WB_Addr != '0)) begin
      rf_q[p_WB_Addr] <= p_WB_Data;
    end
  end

  logic [WIDTH-1:0] data_a_d, data_b_d;

  always_comb begin
    data_a_d = (rs == '0) ? '0 : rf_q[rs];
    data_b_d = (rt == '0) ? '0 : rf_q[rt];
`ifdef ID_WB_BYPASS_EN
    if (p_WB_WE && (p_WB_Addr != '0)) begin
      if (p_WB_Addr == rs) data_a_d = p_WB_Data;
      if (p_WB_Addr == rt) data_b_d = p_WB_Data;
    end
`endif
  end

  // ---------------- hazard detection ----------------
  logic                     ex_valid_q;
  logic [WIDTH-1:0]         data_a_q, data_b_q, imm_q;
  logic [ADDR-1:0]          rt_dest_q, rd_dest_q;
  logic [IE_CTRL_SIZE-1:0]  ie_q;
  logic [MEM_CTRL_SIZE-1:0] mem_q;
  logic [WB_CTRL_SIZE-1:0]  wb_q;
  logic                     hazard;

  id_hazard_unit #(.ADDR(ADDR)) u_hazard (
    .rs_i          (rs),
    .rt_i          (rt),
    .ex_rt_i       (rt_dest_q),
    .ex_mem_read_i (mem_q[MEM_READ_BIT]),
    .ex_valid_i    (ex_valid_q),
    .hazard_o      (hazard)
  );

  // Flush overrides everything so IF can redirect; held during reset so the
  // reset value of the stall output is 0 regardless of p_EX_Stall.
  assign p_ID_Stall = p_reset_l && !p_Flush && (p_EX_Stall || hazard);

  // ---------------- ID/EX registers ----------------
  // Flush and bubble only kill valid and control; the datapath registers hold
  // since nothing downstream consumes them without valid.
  always_ff @(posedge p_clk) begin
    if (!p_reset_l) begin
      ex_valid_q <= 1'b0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      imm_q      <= '0;
      rt_dest_q  <= '0;
      rd_dest_q  <= '0;
      ie_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
    end else if (p_Flush || (!p_EX_Stall && hazard)) begin
      ex_valid_q <= 1'b0;
      ie_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
    end else if (!p_EX_Stall) begin
      ex_valid_q <= p_IF_Valid;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      imm_q      <= imm_d;
      rt_dest_q  <= rt;
      rd_dest_q  <= rd;
      ie_q       <= ie_d;
      mem_q      <= mem_d;
      wb_q       <= wb_d;
    end
  end

  assign p_EX_Valid     = ex_valid_q;
  assign p_DataA        = data_a_q;
  assign p_DataB        = data_b_q;
  assign p_Immediate    = imm_q;
  assign p_RT_RegDest   = rt_dest_q;
  assign p_RD_RegDest   = rd_dest_q;
  assign p_IE_Ctrl_Bus  = ie_q;
  assign p_MEM_Ctrl_Bus = mem_q;
  assign p_WB_Ctrl_Bus  = wb_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe
// Scoreboard bench for id_stage_pipe. The driver applies one input vector per
// cycle, asks a behavioural model what the stage should present, and queues
// that expectation; the monitor pops and compares on every falling edge.
// Directed scenarios add a few literal checks; a random phase follows.
module tb_id_stage_pipe;

  logic        p_clk = 1'b0;
  logic        p_reset_l;
  logic        p_IF_Valid;
  logic [31:0] p_IF_Instruction;
  logic        p_ID_Stall;
  logic        p_EX_Stall;
  logic        p_Flush;
  logic        p_WB_WE;
  logic [4:0]  p_WB_Addr;
  logic [63:0] p_WB_Data;
  logic        p_EX_Valid;
  logic [63:0] p_DataA, p_DataB, p_Immediate;
  logic [4:0]  p_RT_RegDest, p_RD_RegDest;
  logic [7:0]  p_IE_Ctrl_Bus;
  logic [2:0]  p_MEM_Ctrl_Bus;
  logic [1:0]  p_WB_Ctrl_Bus;

  always #5 p_clk = ~p_clk;

  id_stage_pipe dut (
    .p_clk            (p_clk),
    .p_reset_l        (p_reset_l),
    .p_IF_Valid       (p_IF_Valid),
    .p_IF_Instruction (p_IF_Instruction),
    .p_ID_Stall       (p_ID_Stall),
    .p_EX_Stall       (p_EX_Stall),
    .p_Flush          (p_Flush),
    .p_WB_WE          (p_WB_WE),
    .p_WB_Addr        (p_WB_Addr),
    .p_WB_Data        (p_WB_Data),
    .p_EX_Valid       (p_EX_Valid),
    .p_DataA          (p_DataA),
    .p_DataB          (p_DataB),
    .p_Immediate      (p_Immediate),
    .p_RT_RegDest     (p_RT_RegDest),
    .p_RD_RegDest     (p_RD_RegDest),
    .p_IE_Ctrl_Bus    (p_IE_Ctrl_Bus),
    .p_MEM_Ctrl_Bus   (p_MEM_Ctrl_Bus),
    .p_WB_Ctrl_Bus    (p_WB_Ctrl_Bus)
  );

  typedef struct {
    logic        rst_l;
    logic        if_valid;
    logic [31:0] instr;
    logic        ex_stall;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
  } drv_t;

  typedef struct {
    logic        valid;
    logic [63:0] a, b, imm;
    logic [4:0]  rt, rd;
    logic [7:0]  ie;
    logic [2:0]  mem;
    logic [1:0]  wb;
  } bundle_t;

  typedef struct {
    bundle_t b;
    logic    stall;
  } exp_t;

  exp_t        q[$];
  bundle_t     m;
  logic [63:0] mrf [32];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic drv_t idle();
    drv_t d;
    d.rst_l = 1'b1; d.if_valid = 1'b0; d.instr = 32'h0;
    d.ex_stall = 1'b0; d.flush = 1'b0;
    d.wb_we = 1'b0; d.wb_addr = 5'd0; d.wb_data = 64'h0;
    return d;
  endfunction

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Reference control decode, written per instruction class.
  function automatic void ref_ctrl(input logic [5:0] op, output logic [7:0] ie,
                                   output logic [2:0] mem, output logic [1:0] wb);
    bit rtype  = (op == 6'h00);
    bit branch = (op == 6'h04) || (op == 6'h05);
    bit arith  = (op == 6'h08) || (op == 6'h09) || (op == 6'h18) || (op == 6'h19);
    bit slti   = (op == 6'h0A);
    bit logi   = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
    bit lui    = (op == 6'h0F);
    bit load   = (op == 6'h23) || (op == 6'h37);
    bit store  = (op == 6'h2B) || (op == 6'h3F);
    int alu;
    if (rtype)            alu = 6;
    else if (branch)      alu = 1;
    else if (op == 6'h0C) alu = 2;
    else if (op == 6'h0D) alu = 3;
    else if (op == 6'h0E) alu = 4;
    else if (lui)         alu = 5;
    else if (slti)        alu = 7;
    else                  alu = 0;
    ie  = {logi, branch, rtype, arith | slti | logi | lui | load | store, alu[3:0]};
    mem = {(op == 6'h37) || (op == 6'h3F), store, load};
    wb  = {load, rtype | arith | slti | logi | lui | load};
  endfunction

  function automatic logic [63:0] rd_reg(input logic [4:0] r, input drv_t d);
    if (r == 5'd0) return 64'h0;
`ifdef ID_WB_BYPASS_EN
    if (d.wb_we && d.wb_addr == r) return d.wb_data;
`endif
    return mrf[r];
  endfunction

  // Expected outputs for this cycle, then advance the model across the edge.
  task automatic model_step(input drv_t d, output exp_t e);
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic [5:0]  op;
    logic        hz;
    logic [7:0]  ie;
    logic [2:0]  mem;
    logic [1:0]  wb;
    logic [63:0] a, b;
    op  = d.instr[31:26];
    rs  = d.instr[25:21];
    rt  = d.instr[20:16];
    imm = d.instr[15:0];
    hz  = m.valid && m.mem[0] && (m.rt != 0) && (m.rt == rs || m.rt == rt);
    e.b     = m;
    e.stall = d.rst_l && !d.flush && (d.ex_stall || hz);
    a = rd_reg(rs, d);
    b = rd_reg(rt, d);
    if (!d.rst_l) begin
      m = '{default: 0};
      for (int i = 0; i < 32; i++) mrf[i] = 64'h0;
    end else begin
      if (d.flush || (!d.ex_stall && hz)) begin
        m.valid = 1'b0; m.ie = 8'h0; m.mem = 3'h0; m.wb = 2'h0;
      end else if (!d.ex_stall) begin
        ref_ctrl(op, ie, mem, wb);
        m.valid = d.if_valid;
        m.a     = a;
        m.b     = b;
        m.imm   = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ? {48'h0, imm}
                                                              : {{48{imm[15]}}, imm};
        m.rt    = rt;
        m.rd    = d.instr[15:11];
        m.ie    = d.if_valid ? ie  : 8'h0;
        m.mem   = d.if_valid ? mem : 3'h0;
        m.wb    = d.if_valid ? wb  : 2'h0;
      end
      if (d.wb_we && d.wb_addr != 0) mrf[d.wb_addr] = d.wb_data;
    end
  endtask

  task automatic step(input drv_t d);
    exp_t e;
    @(posedge p_clk); #1;
    p_reset_l        = d.rst_l;
    p_IF_Valid       = d.if_valid;
    p_IF_Instruction = d.instr;
    p_EX_Stall       = d.ex_stall;
    p_Flush          = d.flush;
    p_WB_WE          = d.wb_we;
    p_WB_Addr        = d.wb_addr;
    p_WB_Data        = d.wb_data;
    model_step(d, e);
    q.push_back(e);
  endtask

  task automatic at_neg();
    @(negedge p_clk); #1;
  endtask

  always @(negedge p_clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("id_stall", p_ID_Stall, e.stall);
      chk("ex_valid", p_EX_Valid, e.b.valid);
      chk("ie_ctrl", p_IE_Ctrl_Bus, e.b.ie);
      chk("mem_ctrl", p_MEM_Ctrl_Bus, e.b.mem);
      chk("wb_ctrl", p_WB_Ctrl_Bus, e.b.wb);
      if (e.b.valid) begin
        chk("data_a", p_DataA, e.b.a);
        chk("data_b", p_DataB, e.b.b);
        chk("imm", p_Immediate, e.b.imm);
        chk("rt_dest", p_RT_RegDest, e.b.rt);
        chk("rd_dest", p_RD_RegDest, e.b.rd);
      end
    end
  end

  logic [5:0] ops [16] = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D,
                           6'h0E, 6'h0F, 6'h18, 6'h23, 6'h2B, 6'h37, 6'h3F, 6'h3B};

  initial begin
    drv_t d;
    drv_t dep;
    p_reset_l = 1'b0; p_IF_Valid = 1'b0; p_IF_Instruction = 32'h0;
    p_EX_Stall = 1'b0; p_Flush = 1'b0; p_WB_WE = 1'b0;
    p_WB_Addr = 5'd0; p_WB_Data = 64'h0;
    m = '{default: 0};
    for (int i = 0; i < 32; i++) mrf[i] = 64'h0;
    repeat (2) @(posedge p_clk);

    // reset state
    step(idle()); at_neg();
    chk("rst_valid", p_EX_Valid, 1'b0);
    chk("rst_stall", p_ID_Stall, 1'b0);

    // R5 = 0x1234 then read it through rs
    d = idle(); d.wb_we = 1; d.wb_addr = 5; d.wb_data = 64'h1234; step(d);
    d = idle(); d.if_valid = 1; d.instr = 32'h00A00000; step(d);
    step(idle()); at_neg();
    chk("dec_data_a", p_DataA, 64'h1234);
    chk("dec_valid", p_EX_Valid, 1'b1);

    // immediate extension
    d = idle(); d.if_valid = 1; d.instr = ins(6'h0D, 0, 1, 16'h8000); step(d);
    d.instr = ins(6'h08, 0, 1, 16'h8000); step(d); at_neg();
    chk("ori_imm", p_Immediate, 64'h0000_0000_0000_8000);
    step(idle()); at_neg();
    chk("addi_imm", p_Immediate, 64'hFFFF_FFFF_FFFF_8000);

    // load-use: LD r7 then R-type reading r7
    d = idle(); d.if_valid = 1; d.instr = ins(6'h37, 0, 7, 16'h0); step(d);
    dep = idle(); dep.if_valid = 1; dep.instr = ins(6'h00, 7, 0, 16'h0800);
    step(dep); at_neg();
    chk("lu_stall", p_ID_Stall, 1'b1);
    step(dep); at_neg();
    chk("lu_bubble_valid", p_EX_Valid, 1'b0);
    chk("lu_bubble_mem", p_MEM_Ctrl_Bus, 3'h0);
    chk("lu_stall_done", p_ID_Stall, 1'b0);
    step(idle()); at_neg();
    chk("lu_issue_valid", p_EX_Valid, 1'b1);
    chk("lu_issue_ie", p_IE_Ctrl_Bus, 8'h26);
    chk("lu_issue_rd", p_RD_RegDest, 5'd1);

    // same-cycle write-back and read of R3
    d = idle(); d.wb_we = 1; d.wb_addr = 3; d.wb_data = 64'h55; step(d);
    d = idle(); d.if_valid = 1; d.instr = ins(6'h00, 3, 0, 16'h0);
    d.wb_we = 1; d.wb_addr = 3; d.wb_data = 64'hAA; step(d);
    step(idle()); at_neg();
`ifdef ID_WB_BYPASS_EN
    chk("wb_same_cycle", p_DataA, 64'hAA);
`else
    chk("wb_same_cycle", p_DataA, 64'h55);
`endif

    // EX stall held three cycles, then flush during the stall
    d = idle(); d.if_valid = 1; d.instr = ins(6'h0D, 3, 4, 16'h00F0); step(d);
    d = idle(); d.if_valid = 1; d.instr = ins(6'h08, 1, 2, 16'h0005); d.ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step(d); at_neg();
      chk("exs_stall", p_ID_Stall, 1'b1);
      chk("exs_hold_imm", p_Immediate, 64'hF0);
    end
    d.flush = 1; step(d); at_neg();
    chk("flush_stall", p_ID_Stall, 1'b0);
    step(idle()); at_neg();
    chk("flush_valid", p_EX_Valid, 1'b0);

    // R0 stays zero
    d = idle(); d.wb_we = 1; d.wb_addr = 0; d.wb_data = 64'hFFFF;
    d.if_valid = 1; d.instr = ins(6'h00, 0, 0, 16'h0); step(d);
    d = idle(); d.if_valid = 1; d.instr = ins(6'h00, 0, 0, 16'h0); step(d); at_neg();
    chk("r0_same_cycle", p_DataA, 64'h0);
    step(idle()); at_neg();
    chk("r0_after", p_DataA, 64'h0);

    // reset in the middle of a load-use hazard
    d = idle(); d.if_valid = 1; d.instr = ins(6'h23, 0, 9, 16'h0); step(d);
    dep = idle(); dep.if_valid = 1; dep.instr = ins(6'h00, 9, 9, 16'h0); step(dep); at_neg();
    chk("rh_stall", p_ID_Stall, 1'b1);
    dep.rst_l = 0; step(dep); at_neg();
    chk("rh_stall_in_rst", p_ID_Stall, 1'b0);
    d = idle(); d.if_valid = 1; d.instr = ins(6'h00, 5, 0, 16'h0); step(d); at_neg();
    chk("rh_valid", p_EX_Valid, 1'b0);
    chk("rh_data_a", p_DataA, 64'h0);
    chk("rh_imm", p_Immediate, 64'h0);
    chk("rh_ie", p_IE_Ctrl_Bus, 8'h0);
    chk("rh_stall_after", p_ID_Stall, 1'b0);
    step(idle()); at_neg();
    chk("rh_rf_cleared", p_DataA, 64'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] op;
      d.rst_l    = ($urandom_range(0, 199) != 0);
      d.if_valid = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 15)];
      d.instr    = ins(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
      d.ex_stall = ($urandom_range(0, 4) == 0);
      d.flush    = ($urandom_range(0, 15) == 0);
      d.wb_we    = 1'($urandom);
      d.wb_addr  = 5'($urandom_range(0, 7));
      d.wb_data  = {$urandom, $urandom};
      step(d);
    end

    repeat (3) step(idle());
    at_neg();
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised instruction-decode pipeline stage for the MIPS64 core. It sits between the IF stage and the EX stage. It holds the 2^ADDR-entry register file and decodes each 32-bit instruction into operands, immediate and control buses. All decoded results go out through a registered ID/EX boundary with valid, stall and flush handshakes. The stage detects load-use hazards and inserts bubbles itself, and can optionally bypass same-cycle write-back data to its read ports.

## Interface
- WIDTH, 64: datapath/register width; must be ≥16.
- ADDR, 5: register address width; register file depth is 2^ADDR.
- IE_CTRL_SIZE, `IE_CTRL_SIZE: width of the EX control bus.
- MEM_CTRL_SIZE, `MEM_CTRL_SIZE: width of the MEM control bus.
- WB_CTRL_SIZE, `WB_CTRL_SIZE: width of the WB control bus.
- MEM_READ_BIT, 0: index of the load (memory-read) flag in the MEM control bus.

Ports:
- p_clk  in  1  sole clock; rising edge.
- p_reset_l  in  1  synchronous, active-low reset.
- p_IF_Valid  in  1  p_IF_Instruction is valid.
- p_IF_Instruction  in  32  instruction from IF.
- p_ID_Stall  out  1  combinational; IF must hold its instruction this cycle.
- p_EX_Stall  in  1  EX cannot accept; ID/EX registers hold.
- p_Flush  in  1  squash the instruction in ID (branch/exception).
- p_WB_WE, p_WB_Addr[ADDR], p_WB_Data[WIDTH]  in  write-back port.
- p_EX_Valid  out  1  ID/EX bundle is valid.
- p_DataA, p_DataB  out  WIDTH  rs/rt operands.
- p_Immediate  out  WIDTH  extended immediate.
- p_RT_RegDest, p_RD_RegDest  out  ADDR  instr[20:16] and instr[15:11].
- p_IE_Ctrl_Bus, p_MEM_Ctrl_Bus, p_WB_Ctrl_Bus  out  respective control widths.

## Operation
- Field decode: opcode [31:26], rs [25:21], rt [20:16], immediate [15:0]. Control buses come from the shared controller decode.
- Immediate extension: opcodes 0x0C (ANDI), 0x0D (ORI) and 0x0E (XORI) are zero-extended to WIDTH. All other opcodes are sign-extended.
- Register file: write on p_clk when p_WB_WE=1 and p_WB_Addr≠0. Register 0 always reads 0. Reset clears every entry to 0.
- Load-use hazard: raised when p_EX_Valid=1, the held p_MEM_Ctrl_Bus[MEM_READ_BIT]=1, p_RT_RegDest≠0, and p_RT_RegDest equals the incoming rs or rt. On hazard:
  - p_ID_Stall=1.
  - The next ID/EX load is a bubble: p_EX_Valid=0 and all control buses 0.
- Update priority at each edge, highest first:
  1. Reset: all outputs 0.
  2. p_Flush: p_EX_Valid←0, control buses←0.
  3. p_EX_Stall: hold all ID/EX registers. p_ID_Stall=1.
  4. Hazard: bubble.
  5. Normal: load decode results; p_EX_Valid←p_IF_Valid.
- When p_IF_Valid=0, control buses load as 0.
- p_Flush forces p_ID_Stall=0 so that IF can redirect.

## Timing
- Latency: 1 cycle from instruction input to the ID/EX outputs.
- Reset value of every output is 0, including p_EX_Valid and p_ID_Stall.
- p_ID_Stall is combinational from current inputs and the held ID/EX state. A load-use stall lasts exactly one cycle unless p_EX_Stall extends it.
- A write and a read of the same register in the same cycle return the data described under Configuration.
- Reset asserted mid-stall or mid-flush: state clears on that edge and the hazard is forgotten.

## Configuration
- ID_WB_BYPASS_EN defined: when p_WB_WE=1 and p_WB_Addr matches rs or rt (address ≠0), the operand takes p_WB_Data in the same cycle.
- ID_WB_BYPASS_EN undefined: operands come from the array only, so the same-cycle read returns the old value. In this build the core must provide forwarding downstream.

## Structure
- Shared package/header: WIDTH/ADDR defaults, control-bus sizes, MEM_READ_BIT, and the opcode constants OP_ANDI, OP_ORI, OP_XORI.
- One sub-module, id_hazard_unit. It is purely combinational: it takes rs, rt, the held EX destination, the EX load flag and p_EX_Valid, and produces the hazard flag.
- The register file array, extension logic and ID/EX registers are written inline.

## Test plan
- Reset, then write R5=0x1234 via the WB port. Decode instruction 0x00A00000 → p_DataA=0x1234 one cycle later, p_EX_Valid=1.
- ORI with imm 0x8000 → p_Immediate=0x0000_0000_0000_8000. ADDI with imm 0x8000 → p_Immediate=0xFFFF_FFFF_FFFF_8000.
- Load to rt=7 followed by an instruction reading rs=7 → p_ID_Stall=1 for one cycle, one bubble (p_EX_Valid=0, control 0), then the dependent instruction issues.
- p_WB_WE=1, Addr=3, Data=0xAA while decoding a read of R3:
  - With ID_WB_BYPASS_EN → 0xAA.
  - Without it → previous value.
- p_EX_Stall held 3 cycles → all outputs stable. p_Flush asserted during the stall → p_EX_Valid=0 next edge.
- Write to R0 with 0xFFFF → a read of R0 returns 0. Reset asserted mid-hazard → all outputs 0, p_ID_Stall=0.
